// File: rtl/usb_packet_receiver_pkg.sv
// usb_packet_receiver_pkg: bus, PID, error and FSM types plus CRC5 constants for the USB receive path
package usb_packet_receiver_pkg;
  typedef enum logic [1:0] {BUS_SE0 = 2'b00, BUS_K = 2'b01, BUS_J = 2'b10, BUS_SE1 = 2'b11} bus_state_t;
  typedef enum logic [3:0] {
    PID_OUT = 4'b0001, PID_IN = 4'b1001, PID_SETUP = 4'b1101, PID_SOF = 4'b0101,
    PID_ACK = 4'b0010, PID_NAK = 4'b1010, PID_STALL = 4'b1110
  } pid_t;
  typedef enum logic [2:0] {
    ERR_NONE, ERR_SYNC, ERR_PID, ERR_STUFF, ERR_CRC, ERR_EOP, ERR_SE1, ERR_UNSUP
  } rx_err_t;
  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_PID, ST_TOKEN, ST_EOP, ST_WAIT} rx_state_t;
  localparam logic [4:0] CRC5_INIT = 5'b11111;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;
  function automatic logic is_token(input logic [3:0] p);
    return p inside {PID_OUT, PID_IN, PID_SETUP, PID_SOF};
  endfunction
  function automatic logic is_handshake(input logic [3:0] p);
    return p inside {PID_ACK, PID_NAK, PID_STALL};
  endfunction
endpackage

// File: rtl/usb_rx_bit_decoder.sv
// usb_rx_bit_decoder: NRZI decode of J/K samples with removal of stuffed bits
// Ports: i_en (sample is J or K), i_k (sample is K), i_start (compare against J instead of stored level),
//        i_unstuff_en (stuffing active, otherwise ones run cleared); o_bit, o_bit_valid (low on discarded
//        stuffed bit), o_stuff_err (stuffed position carried a 1).
module usb_rx_bit_decoder (
  input  logic clock,
  input  logic reset_n,
  input  logic i_en,
  input  logic i_k,
  input  logic i_start,
  input  logic i_unstuff_en,
  output logic o_bit,
  output logic o_bit_valid,
  output logic o_stuff_err
);
  logic       r_prev_k;
  logic [2:0] r_ones;
  logic       w_stuffed;
  assign o_bit       = i_k == (r_prev_k & ~i_start);
  assign w_stuffed   = i_unstuff_en && r_ones == 3'd6;
  assign o_bit_valid = i_en && !w_stuffed;
  assign o_stuff_err = i_en && w_stuffed && o_bit;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_prev_k <= 1'b0;
      r_ones   <= 3'd0;
    end else if (i_en) begin
      r_prev_k <= i_k;
      r_ones   <= (!i_unstuff_en || w_stuffed || !o_bit) ? 3'd0 : r_ones + 3'd1;
    end
endmodule

// File: rtl/usb_packet_receiver.sv
// usb_packet_receiver: SYNC/PID/token/handshake receiver for the sampled USB DP/DM pair
// Ports: clock, reset_n (async, active low), dp/dm (one sample per clock);
//        pkt_valid/pkt_error (one-cycle pulses), err_code (last error cause),
//        pid/addr/endp (fields of last good packet), busy (packet in progress).
module usb_packet_receiver
  import usb_packet_receiver_pkg::*;
#(
  parameter int EOP_SE0_LEN  = 2,
  parameter int IDLE_RECOVER = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       dp,
  input  logic       dm,
  output logic       pkt_valid,
  output logic       pkt_error,
  output logic [2:0] err_code,
  output logic [3:0] pid,
  output logic [6:0] addr,
  output logic [3:0] endp,
  output logic       busy
);
  rx_state_t  r_state, w_next;
  rx_err_t    r_err_code, w_code;
  bus_state_t w_bus;
  logic [4:0] r_cnt, r_crc, w_crc;
  logic [6:0] r_byte, r_addr;
  logic [10:0] r_tok;
  logic [3:0] r_pid, r_endp, r_se0, r_jcnt;
  logic       r_valid, r_err, r_busy, r_seen_se0;
  logic       w_line, w_bit, w_bit_valid, w_stuff_err, w_done;
  logic [7:0] w_byte;
  assign w_bus  = bus_state_t'({dp, dm});
  assign w_line = w_bus == BUS_J || w_bus == BUS_K;
  assign w_byte = {w_bit, r_byte};
  assign w_crc  = {r_crc[3:0], 1'b0} ^ ({5{w_bit ^ r_crc[4]}} & 5'b00101);
  usb_rx_bit_decoder u_dec (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_en        (w_line),
    .i_k         (w_bus == BUS_K),
    .i_start     (r_state == ST_IDLE),
    .i_unstuff_en(r_state inside {ST_PID, ST_TOKEN, ST_EOP}),
    .o_bit       (w_bit),
    .o_bit_valid (w_bit_valid),
    .o_stuff_err (w_stuff_err)
  );
  always_comb begin
    w_next = r_state;
    w_code = ERR_NONE;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: w_next = (w_bus == BUS_K) ? ST_SYNC : w_line ? ST_IDLE : ST_WAIT;
      ST_SYNC:
        if (!w_line || w_bit != (r_cnt == 5'd7)) w_code = ERR_SYNC;
        else if (r_cnt == 5'd7) w_next = ST_PID;
      ST_PID:
        if (!w_line) w_code = ERR_EOP;
        else if (w_stuff_err) w_code = ERR_STUFF;
        else if (w_bit_valid && r_cnt == 5'd7) begin
          if (w_byte[7:4] != ~w_byte[3:0]) w_code = ERR_PID;
          else if (is_token(w_byte[3:0])) w_next = ST_TOKEN;
          else if (is_handshake(w_byte[3:0])) w_next = ST_EOP;
          else w_code = ERR_UNSUP;
        end
      ST_TOKEN:
        if (!w_line) w_code = ERR_EOP;
        else if (w_stuff_err) w_code = ERR_STUFF;
        else if (w_bit_valid && r_cnt == 5'd15) begin
          if (w_crc != CRC5_RESIDUAL) w_code = ERR_CRC;
          else w_next = ST_EOP;
        end
      // a stuffed 0 trailing the last field bit is discarded; any real bit before SE0 is an EOP error
      ST_EOP:
        if (w_bus == BUS_SE0) begin
          if (r_se0 == 4'(EOP_SE0_LEN)) w_code = ERR_EOP;
        end else if (r_se0 == 4'd0) begin
          if (w_bit_valid || w_stuff_err) w_code = ERR_EOP;
        end else if (w_bus == BUS_J && r_se0 == 4'(EOP_SE0_LEN)) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end else w_code = ERR_EOP;
      ST_WAIT:
        if (w_bus == BUS_J && (r_seen_se0 || r_jcnt == 4'(IDLE_RECOVER - 1))) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (w_bus == BUS_SE1 && r_state != ST_IDLE && r_state != ST_WAIT) w_code = ERR_SE1;
    if (w_code != ERR_NONE) w_next = ST_WAIT;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_cnt      <= 5'd0;
      r_crc      <= CRC5_INIT;
      r_byte     <= 7'd0;
      r_tok      <= 11'd0;
      r_se0      <= 4'd0;
      r_jcnt     <= 4'd0;
      r_seen_se0 <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_err_code <= ERR_NONE;
      r_pid      <= 4'd0;
      r_addr     <= 7'd0;
      r_endp     <= 4'd0;
    end else begin
      r_cnt      <= (r_state == ST_IDLE) ? 5'd1 : (w_next != r_state) ? 5'd0 : w_bit_valid ? r_cnt + 5'd1 : r_cnt;
      r_crc      <= (r_state == ST_PID) ? CRC5_INIT : (r_state == ST_TOKEN && w_bit_valid) ? w_crc : r_crc;
      if (r_state == ST_PID && w_bit_valid && r_cnt < 5'd7) r_byte[r_cnt[2:0]] <= w_bit;
      if (r_state == ST_TOKEN && w_bit_valid && r_cnt < 5'd11) r_tok[r_cnt[3:0]] <= w_bit;
      r_se0      <= (r_state != ST_EOP) ? 4'd0 : (w_bus == BUS_SE0) ? r_se0 + 4'd1 : r_se0;
      r_jcnt     <= (r_state == ST_WAIT && w_bus == BUS_J) ? r_jcnt + 4'd1 : 4'd0;
      r_seen_se0 <= r_state == ST_WAIT && w_bus == BUS_SE0;
      r_valid    <= w_done;
      r_err      <= w_code != ERR_NONE;
      // a K accepted during the pulse cycle (back-to-back) keeps busy asserted
      r_busy     <= (r_state == ST_IDLE && w_bus == BUS_K) || (r_busy && !(r_valid || r_err));
      r_err_code <= w_done ? ERR_NONE : (w_code != ERR_NONE) ? w_code : r_err_code;
      if (w_done) begin
        r_pid <= r_byte[3:0];
        if (is_token(r_byte[3:0])) begin
          r_addr <= r_tok[6:0];
          r_endp <= r_tok[10:7];
        end
      end
    end
  assign pkt_valid = r_valid;
  assign pkt_error = r_err;
  assign err_code  = r_err_code;
  assign pid       = r_pid;
  assign addr      = r_addr;
  assign endp      = r_endp;
  assign busy      = r_busy;
endmodule

// File: tb/tb_usb_packet_receiver.sv
// tb_usb_packet_receiver: directed packet streams from a token-transmitter model, checked against hand-derived results
module tb_usb_packet_receiver;
  logic clock = 1'b0, reset_n = 1'b0, dp = 1'b1, dm = 1'b0;
  logic pkt_valid, pkt_error, busy;
  logic [2:0] err_code;
  logic [3:0] pid, endp;
  logic [6:0] addr;
  int n_tests = 0, n_fail = 0, n_valid = 0, n_err = 0, n_busy = 0, n_both = 0;
  logic [2:0] cap_code = 3'd0;
  logic [1:0] lv[$];
  logic cur_k;
  int ones, stuff_idx, bad_stuff;
  int dv, de, db, v0, e0;
  usb_packet_receiver dut (
    .clock(clock), .reset_n(reset_n), .dp(dp), .dm(dm),
    .pkt_valid(pkt_valid), .pkt_error(pkt_error), .err_code(err_code),
    .pid(pid), .addr(addr), .endp(endp), .busy(busy)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (pkt_valid) n_valid++;
    if (pkt_error) begin
      n_err++;
      cap_code = err_code;
    end
    if (busy) n_busy++;
    if (pkt_valid && pkt_error) n_both++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic nrzi(input logic b);
    if (!b) cur_k = ~cur_k;
    lv.push_back(cur_k ? 2'b01 : 2'b10);
  endtask
  task automatic put_data(input logic b);
    nrzi(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      nrzi(stuff_idx == bad_stuff);
      stuff_idx++;
      ones = 0;
    end
  endtask
  task automatic start_pkt(input int bad);
    cur_k = 1'b0;
    ones = 0;
    stuff_idx = 0;
    bad_stuff = bad;
    for (int i = 0; i < 8; i++) nrzi(i == 7);
  endtask
  task automatic put_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) put_data(v[i]);
  endtask
  task automatic put_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e, input logic [4:0] flip);
    logic [10:0] d;
    logic [4:0] c;
    d = {e, a};
    c = 5'b11111;
    put_bits({8'h00, ~p, p}, 8);
    put_bits({5'd0, d}, 11);
    for (int i = 0; i < 11; i++) c = {c[3:0], 1'b0} ^ ((d[i] ^ c[4]) ? 5'b00101 : 5'b00000);
    c = ~c ^ flip;
    for (int i = 4; i >= 0; i--) put_data(c[i]);
  endtask
  task automatic put_eop(input int n);
    repeat (n) lv.push_back(2'b00);
    lv.push_back(2'b10);
  endtask
  task automatic push_j(input int n);
    repeat (n) lv.push_back(2'b10);
  endtask
  task automatic play();
    foreach (lv[i]) begin
      @(posedge clock);
      #1 {dp, dm} = lv[i];
    end
    lv.delete();
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1 {dp, dm} = 2'b10;
    end
  endtask
  task automatic send(output int o_dv, output int o_de, output int o_db);
    int sv, se, sb;
    sv = n_valid;
    se = n_err;
    sb = n_busy;
    play();
    idle(4);
    o_dv = n_valid - sv;
    o_de = n_err - se;
    o_db = n_busy - sb;
  endtask
  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    check("rst_valid", pkt_valid, 0);
    check("rst_error", pkt_error, 0);
    check("rst_busy", busy, 0);
    check("rst_pid", pid, 0);
    check("rst_addr", addr, 0);
    check("rst_endp", endp, 0);
    check("rst_code", err_code, 0);
    start_pkt(-1); put_token(4'b0001, 7'h05, 4'h4, 5'h00); put_eop(2); send(dv, de, db);
    check("out_valid", dv, 1);
    check("out_error", de, 0);
    check("out_pid", pid, 4'b0001);
    check("out_addr", addr, 7'h05);
    check("out_endp", endp, 4'h4);
    check("out_code", err_code, 0);
    check("out_busy_cycles", db, 35);
    start_pkt(-1); put_token(4'b1101, 7'h7F, 4'hF, 5'h00); put_eop(2); send(dv, de, db);
    check("setup_valid", dv, 1);
    check("setup_pid", pid, 4'b1101);
    check("setup_addr", addr, 7'h7F);
    check("setup_endp", endp, 4'hF);
    start_pkt(0); put_token(4'b1101, 7'h7F, 4'hF, 5'h00); put_eop(2); send(dv, de, db);
    check("stuff_error", de, 1);
    check("stuff_novalid", dv, 0);
    check("stuff_code", cap_code, 3);
    start_pkt(-1); put_token(4'b0001, 7'h05, 4'h4, 5'h04); put_eop(2); send(dv, de, db);
    check("crc_error", de, 1);
    check("crc_code", cap_code, 4);
    check("crc_code_held", err_code, 4);
    check("crc_pid_kept", pid, 4'b1101);
    check("crc_addr_kept", addr, 7'h7F);
    start_pkt(-1); put_bits(16'h00D2, 8); put_eop(2); send(dv, de, db);
    check("ack_valid", dv, 1);
    check("ack_pid", pid, 4'b0010);
    check("ack_code_clr", err_code, 0);
    check("ack_addr_kept", addr, 7'h7F);
    start_pkt(-1); put_bits(16'h0002, 8); put_eop(2); send(dv, de, db);
    check("pidchk_error", de, 1);
    check("pidchk_code", cap_code, 2);
    start_pkt(-1); put_bits(16'h00C3, 8); put_eop(2); send(dv, de, db);
    check("unsup_error", de, 1);
    check("unsup_code", cap_code, 7);
    start_pkt(-1); put_token(4'b0001, 7'h05, 4'h4, 5'h00); put_eop(1); push_j(8);
    start_pkt(-1); put_token(4'b0001, 7'h33, 4'h2, 5'h00); put_eop(2); send(dv, de, db);
    check("eop_error", de, 1);
    check("eop_code", cap_code, 5);
    check("eop_recover_valid", dv, 1);
    check("eop_recover_addr", addr, 7'h33);
    check("eop_recover_endp", endp, 4'h2);
    start_pkt(-1); put_bits(16'h00E1, 8); put_bits(16'h0005, 3); lv.push_back(2'b11); push_j(8);
    start_pkt(-1); put_token(4'b1001, 7'h40, 4'h7, 5'h00); put_eop(2); send(dv, de, db);
    check("se1_error", de, 1);
    check("se1_code", cap_code, 6);
    check("se1_recover_valid", dv, 1);
    check("se1_recover_pid", pid, 4'b1001);
    check("se1_recover_addr", addr, 7'h40);
    start_pkt(-1); put_bits(16'h00E1, 8); lv.push_back(2'b11); push_j(7);
    start_pkt(-1); put_token(4'b0001, 7'h12, 4'h3, 5'h00); put_eop(2); send(dv, de, db);
    check("short_recover_error", de, 1);
    check("short_recover_novalid", dv, 0);
    check("short_recover_addr", addr, 7'h40);
    start_pkt(-1); put_bits(16'h00D2, 8); put_eop(2);
    start_pkt(-1); put_token(4'b1001, 7'h11, 4'h1, 5'h00); put_eop(2); send(dv, de, db);
    check("b2b_valid", dv, 2);
    check("b2b_error", de, 0);
    check("b2b_addr", addr, 7'h11);
    check("b2b_pid", pid, 4'b1001);
    v0 = n_valid;
    e0 = n_err;
    start_pkt(-1); put_bits(16'h00E1, 8); put_bits(16'h0005, 3); play();
    #3 check("midrst_busy_before", busy, 1);
    reset_n = 1'b0;
    #1 check("midrst_busy", busy, 0);
    check("midrst_pid", pid, 0);
    check("midrst_addr", addr, 0);
    check("midrst_endp", endp, 0);
    {dp, dm} = 2'b10;
    @(negedge clock) reset_n = 1'b1;
    idle(2);
    check("midrst_no_pulse", (n_valid - v0) + (n_err - e0), 0);
    start_pkt(-1); put_token(4'b0001, 7'h2A, 4'h9, 5'h00); put_eop(2); send(dv, de, db);
    check("loop_valid", dv, 1);
    check("loop_pid", pid, 4'b0001);
    check("loop_addr", addr, 7'h2A);
    check("loop_endp", endp, 4'h9);
    check("never_both", n_both, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
